// File: rtl/cm_config_engine_if.sv
// Byte-stream and config-bus bundle for the Color Manager configuration engine.
// The engine (master) pops the RX FIFO and drives the held valid/ready config write.
interface cm_config_engine_if #(
    parameter int UART_DATA_WIDTH = 8,
    parameter int C_ADDR_WIDTH    = 4,
    parameter int C_DATA_WIDTH    = 14
);
    logic                       Empty;
    logic [UART_DATA_WIDTH-1:0] RXD_Data;
    logic                       Rd_En;
    logic                       C_Rdy;
    logic                       C_Valid;
    logic [C_ADDR_WIDTH-1:0]    C_Addr;
    logic [C_DATA_WIDTH-1:0]    C_Data;

    modport master (
        input  Empty, RXD_Data, C_Rdy,
        output Rd_En, C_Valid, C_Addr, C_Data
    );

    modport slave (
        output Empty, RXD_Data, C_Rdy,
        input  Rd_En, C_Valid, C_Addr, C_Data
    );
endinterface

// File: rtl/cm_config_engine.sv
// Assembles FIFO bytes into command words, range-checks them and delivers
// config/colour writes on a held valid/ready bus with shadow status and error reporting.
module cm_config_engine #(
    parameter int UART_DATA_WIDTH = 8,
    parameter int WORD_BYTES      = 2,
    parameter int C_ADDR_WIDTH    = 4,
    parameter int C_DATA_WIDTH    = 14,
    parameter int NUM_CFG_REGS    = 4,
    parameter int CFG_REG_WIDTH   = 4,
    parameter logic [NUM_CFG_REGS*CFG_REG_WIDTH-1:0] REG_MAX        = 16'h2125,
    parameter logic [NUM_CFG_REGS*CFG_REG_WIDTH-1:0] DEFAULT_STATUS = 16'h0002,
    parameter logic [C_ADDR_WIDTH-1:0]               COLOR_ADDR     = 4'hF,
    parameter int TIMEOUT_CYCLES  = 16
) (
    input  logic                                  Clk,
    input  logic                                  Rst,
    cm_config_engine_if.master                    bus,
    output logic [NUM_CFG_REGS*CFG_REG_WIDTH-1:0] Config_Status,
    output logic [C_ADDR_WIDTH-1:0]               Config_Notification,
    output logic                                  Config_Notification_Valid,
    output logic [2:0]                            Config_Error,
    output logic                                  Error_Valid
);
    localparam int W      = WORD_BYTES * UART_DATA_WIDTH;
    localparam int BW     = $clog2(WORD_BYTES + 1);
    localparam int TW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic TMO_EN = (TIMEOUT_CYCLES != 32'sd0);
    localparam logic [BW-1:0] BYTE_LAST = BW'(WORD_BYTES - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [C_ADDR_WIDTH:0] NUM_REGS_A = (C_ADDR_WIDTH + 1)'(NUM_CFG_REGS);

    typedef enum logic [2:0] {IDLE, ASSEMBLE, DECODE, DELIVER, ERR} state_t;

    state_t                   state_r;
    logic [W-1:0]             word_r;
    logic [BW-1:0]            byte_cnt_r;
    logic [TW-1:0]            tmo_cnt_r;
    logic                     is_cfg_r;
    logic                     dec_cfg_s;
    logic [2:0]               dec_err_s;
    logic [C_ADDR_WIDTH-1:0]  dec_addr_s;
    logic [C_DATA_WIDTH-1:0]  dec_data_s;
    logic [C_ADDR_WIDTH-1:0]  cfg_addr_s;
    logic [CFG_REG_WIDTH-1:0] cfg_val_s;

    function automatic logic [CFG_REG_WIDTH-1:0] reg_max_of(input logic [C_ADDR_WIDTH-1:0] addr);
        logic [CFG_REG_WIDTH-1:0] m;
        m = {CFG_REG_WIDTH{1'b0}};
        for (int i = 0; i < NUM_CFG_REGS; i++) begin
            m = (addr == C_ADDR_WIDTH'(i)) ? REG_MAX[i*CFG_REG_WIDTH +: CFG_REG_WIDTH] : m;
        end
        return m;
    endfunction

    // Wide scratch vector lets any source width be zero-extended or truncated.
    function automatic logic [C_DATA_WIDTH-1:0] resize_colour(input logic [W-1:0] word);
        logic [W+C_DATA_WIDTH-1:0] ext;
        ext = {(W + C_DATA_WIDTH){1'b0}};
        ext[W-3:0] = word[W-3:0];
        return ext[C_DATA_WIDTH-1:0];
    endfunction

    function automatic logic [C_DATA_WIDTH-1:0] resize_value(input logic [CFG_REG_WIDTH-1:0] v);
        logic [CFG_REG_WIDTH+C_DATA_WIDTH-1:0] ext;
        ext = {(CFG_REG_WIDTH + C_DATA_WIDTH){1'b0}};
        ext[CFG_REG_WIDTH-1:0] = v;
        return ext[C_DATA_WIDTH-1:0];
    endfunction

    // FIFO pop strobe: only while collecting bytes, forced low during reset.
    assign bus.Rd_En = !Rst && ((state_r == IDLE) || (state_r == ASSEMBLE)) && !bus.Empty;

    assign dec_cfg_s  = word_r[W-1];
    assign cfg_addr_s = word_r[W-2 -: C_ADDR_WIDTH];
    assign cfg_val_s  = word_r[CFG_REG_WIDTH-1:0];

    // Classify the assembled word and check it against the per-register limits.
    always_comb begin
        dec_err_s  = 3'd0;
        dec_addr_s = {C_ADDR_WIDTH{1'b0}};
        dec_data_s = {C_DATA_WIDTH{1'b0}};
        if (dec_cfg_s) begin
            dec_addr_s = cfg_addr_s;
            dec_data_s = resize_value(cfg_val_s);
            if ({1'b0, cfg_addr_s} >= NUM_REGS_A) begin
                dec_err_s = 3'd1;
            end else if (cfg_val_s > reg_max_of(cfg_addr_s)) begin
                dec_err_s = 3'd2;
            end else begin
                dec_err_s = 3'd0;
            end
        end else begin
            dec_addr_s = COLOR_ADDR;
            dec_data_s = resize_colour(word_r);
            if (word_r[W-2]) begin
                dec_err_s = 3'd3;
            end else begin
                dec_err_s = 3'd0;
            end
        end
    end

    // Main control FSM with all registered outputs.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_r                   <= IDLE;
            word_r                    <= {W{1'b0}};
            byte_cnt_r                <= {BW{1'b0}};
            tmo_cnt_r                 <= {TW{1'b0}};
            is_cfg_r                  <= 1'b0;
            bus.C_Valid               <= 1'b0;
            bus.C_Addr                <= {C_ADDR_WIDTH{1'b0}};
            bus.C_Data                <= {C_DATA_WIDTH{1'b0}};
            Config_Status             <= DEFAULT_STATUS;
            Config_Notification       <= {C_ADDR_WIDTH{1'b0}};
            Config_Notification_Valid <= 1'b0;
            Config_Error              <= 3'd0;
            Error_Valid               <= 1'b0;
        end else begin
            Config_Notification_Valid <= 1'b0;
            case (state_r)
                IDLE, ASSEMBLE: begin
                    if (bus.Rd_En) begin
                        word_r    <= (state_r == IDLE) ? W'(bus.RXD_Data)
                                                       : ((word_r << UART_DATA_WIDTH) | W'(bus.RXD_Data));
                        tmo_cnt_r <= {TW{1'b0}};
                        if (byte_cnt_r == BYTE_LAST) begin
                            byte_cnt_r <= {BW{1'b0}};
                            state_r    <= DECODE;
                        end else begin
                            byte_cnt_r <= byte_cnt_r + BW'(1);
                            state_r    <= ASSEMBLE;
                        end
                    end else if (state_r == ASSEMBLE && TMO_EN && tmo_cnt_r == TMO_LAST) begin
                        byte_cnt_r   <= {BW{1'b0}};
                        tmo_cnt_r    <= {TW{1'b0}};
                        Config_Error <= 3'd4;
                        Error_Valid  <= 1'b1;
                        state_r      <= ERR;
                    end else if (state_r == ASSEMBLE) begin
                        tmo_cnt_r <= tmo_cnt_r + TW'(1);
                    end else begin
                        tmo_cnt_r <= {TW{1'b0}};
                    end
                end
                DECODE: begin
                    tmo_cnt_r <= {TW{1'b0}};
                    if (dec_err_s != 3'd0) begin
                        Config_Error <= dec_err_s;
                        Error_Valid  <= 1'b1;
                        state_r      <= ERR;
                    end else begin
                        bus.C_Valid <= 1'b1;
                        bus.C_Addr  <= dec_addr_s;
                        bus.C_Data  <= dec_data_s;
                        is_cfg_r    <= dec_cfg_s;
                        state_r     <= DELIVER;
                    end
                end
                DELIVER: begin
                    if (bus.C_Rdy) begin
                        bus.C_Valid <= 1'b0;
                        if (is_cfg_r) begin
                            for (int i = 0; i < NUM_CFG_REGS; i++) begin
                                if (bus.C_Addr == C_ADDR_WIDTH'(i)) begin
                                    Config_Status[i*CFG_REG_WIDTH +: CFG_REG_WIDTH] <= bus.C_Data[CFG_REG_WIDTH-1:0];
                                end
                            end
                            Config_Notification       <= bus.C_Addr;
                            Config_Notification_Valid <= 1'b1;
                        end
                        state_r <= IDLE;
                    end else if (TMO_EN && tmo_cnt_r == TMO_LAST) begin
                        bus.C_Valid  <= 1'b0;
                        tmo_cnt_r    <= {TW{1'b0}};
                        Config_Error <= 3'd5;
                        Error_Valid  <= 1'b1;
                        state_r      <= ERR;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TW'(1);
                    end
                end
                ERR: begin
                    Error_Valid <= 1'b0;
                    state_r     <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cm_config_engine.sv
// Directed, table-driven bench for cm_config_engine with hand-written timeout/reset sequences.
module tb_cm_config_engine;
    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [15:0] Config_Status;
    logic [3:0]  Config_Notification;
    logic        Config_Notification_Valid;
    logic [2:0]  Config_Error;
    logic        Error_Valid;
    int          errors = 0;
    int          checks = 0;

    cm_config_engine_if #(.UART_DATA_WIDTH(8), .C_ADDR_WIDTH(4), .C_DATA_WIDTH(14)) bus ();

    cm_config_engine dut (
        .Clk                       (Clk),
        .Rst                       (Rst),
        .bus                       (bus),
        .Config_Status             (Config_Status),
        .Config_Notification       (Config_Notification),
        .Config_Notification_Valid (Config_Notification_Valid),
        .Config_Error              (Config_Error),
        .Error_Valid               (Error_Valid)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        int          dly;     // cycles C_Rdy stays low in DELIVER
        int          kind;    // 0 config commit, 1 colour write, 2 decode error
        logic [3:0]  addr;
        logic [13:0] data;
        logic [2:0]  err;
        logic [15:0] status;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        @(negedge Clk);
        bus.Empty    = 1'b0;
        bus.RXD_Data = b;
        #1;
        n = 0;
        while (bus.Rd_En !== 1'b1 && n < 20) begin
            @(negedge Clk);
            #1;
            n++;
        end
        if (bus.Rd_En !== 1'b1) chk("rd_en_wait", 32'(bus.Rd_En), 32'd1);
        @(posedge Clk);
    endtask

    task automatic apply_vec(input vec_t v);
        int   held;
        logic unstable;
        send_byte(v.b0);
        send_byte(v.b1);
        @(negedge Clk);
        chk("decode_c_valid", 32'(bus.C_Valid), 32'd0);
        chk("decode_no_pop", 32'(bus.Rd_En), 32'd0);
        @(negedge Clk);
        if (v.kind == 2) begin
            chk("err_pulse", 32'(Error_Valid), 32'd1);
            chk("err_code", 32'(Config_Error), 32'(v.err));
            chk("err_no_valid", 32'(bus.C_Valid), 32'd0);
            bus.Empty = 1'b1;
            @(negedge Clk);
            chk("err_pulse_end", 32'(Error_Valid), 32'd0);
            chk("err_no_notify", 32'(Config_Notification_Valid), 32'd0);
            chk("err_status", 32'(Config_Status), 32'(v.status));
        end else begin
            chk("deliver_valid", 32'(bus.C_Valid), 32'd1);
            chk("deliver_addr", 32'(bus.C_Addr), 32'(v.addr));
            chk("deliver_data", 32'(bus.C_Data), 32'(v.data));
            chk("deliver_no_pop", 32'(bus.Rd_En), 32'd0);
            bus.Empty = 1'b1;
            held      = 0;
            unstable  = 1'b0;
            while (bus.C_Valid === 1'b1 && held < 40) begin
                if (bus.C_Addr !== v.addr || bus.C_Data !== v.data) unstable = 1'b1;
                bus.C_Rdy = (held >= v.dly);
                held++;
                @(negedge Clk);
            end
            chk("valid_held_cycles", 32'(held), 32'(v.dly + 1));
            chk("bus_stable", 32'(unstable), 32'd0);
            chk("notify_pulse", 32'(Config_Notification_Valid), (v.kind == 0) ? 32'd1 : 32'd0);
            if (v.kind == 0) chk("notify_addr", 32'(Config_Notification), 32'(v.addr));
            chk("commit_status", 32'(Config_Status), 32'(v.status));
            bus.C_Rdy = 1'b0;
            @(negedge Clk);
            chk("notify_pulse_end", 32'(Config_Notification_Valid), 32'd0);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_c_valid"}, 32'(bus.C_Valid), 32'd0);
        chk({tag, "_c_addr"}, 32'(bus.C_Addr), 32'd0);
        chk({tag, "_c_data"}, 32'(bus.C_Data), 32'd0);
        chk({tag, "_status"}, 32'(Config_Status), 32'h0002);
        chk({tag, "_notify"}, 32'(Config_Notification), 32'd0);
        chk({tag, "_notify_v"}, 32'(Config_Notification_Valid), 32'd0);
        chk({tag, "_err"}, 32'(Config_Error), 32'd0);
        chk({tag, "_err_v"}, 32'(Error_Valid), 32'd0);
        chk({tag, "_rd_en"}, 32'(bus.Rd_En), 32'd0);
    endtask

    vec_t vecs[11];

    initial begin
        int n;
        vecs[0]  = '{8'h88, 8'h02, 0, 0, 4'h1, 14'h0002, 3'd0, 16'h0022};
        vecs[1]  = '{8'h12, 8'h34, 5, 1, 4'hF, 14'h1234, 3'd0, 16'h0022};
        vecs[2]  = '{8'hA8, 8'h00, 0, 2, 4'h0, 14'h0000, 3'd1, 16'h0022};
        vecs[3]  = '{8'h80, 8'h07, 0, 2, 4'h0, 14'h0000, 3'd2, 16'h0022};
        vecs[4]  = '{8'h40, 8'h00, 0, 2, 4'h0, 14'h0000, 3'd3, 16'h0022};
        vecs[5]  = '{8'h80, 8'h05, 1, 0, 4'h0, 14'h0005, 3'd0, 16'h0025};
        vecs[6]  = '{8'h90, 8'h01, 0, 0, 4'h2, 14'h0001, 3'd0, 16'h0125};
        vecs[7]  = '{8'h98, 8'h02, 2, 0, 4'h3, 14'h0002, 3'd0, 16'h2125};
        vecs[8]  = '{8'h3F, 8'hFF, 0, 1, 4'hF, 14'h3FFF, 3'd0, 16'h2125};
        vecs[9]  = '{8'h98, 8'h03, 0, 2, 4'h0, 14'h0000, 3'd2, 16'h2125};
        vecs[10] = '{8'h90, 8'h00, 0, 0, 4'h2, 14'h0000, 3'd0, 16'h2025};

        bus.Empty    = 1'b0;
        bus.RXD_Data = 8'hAA;
        bus.C_Rdy    = 1'b0;
        repeat (3) @(negedge Clk);
        chk_reset_outputs("reset");
        Rst       = 1'b0;
        bus.Empty = 1'b1;
        @(negedge Clk);

        for (int i = 0; i < 11; i++) apply_vec(vecs[i]);

        // Byte timeout: partial word discarded, next word assembles cleanly.
        send_byte(8'h88);
        @(negedge Clk);
        bus.Empty = 1'b1;
        n = 0;
        while (Error_Valid !== 1'b1 && n < 40) begin
            chk("byte_tmo_no_valid", 32'(bus.C_Valid), 32'd0);
            @(negedge Clk);
            n++;
        end
        chk("byte_tmo_pulse", 32'(Error_Valid), 32'd1);
        chk("byte_tmo_code", 32'(Config_Error), 32'd4);
        @(negedge Clk);
        apply_vec('{8'h90, 8'h01, 0, 0, 4'h2, 14'h0001, 3'd0, 16'h2125});

        // Delivery timeout: write dropped after 16 cycles, register 3 untouched.
        send_byte(8'h98);
        send_byte(8'h01);
        @(negedge Clk);
        @(negedge Clk);
        chk("dlv_tmo_valid", 32'(bus.C_Valid), 32'd1);
        bus.Empty = 1'b1;
        n = 0;
        while (bus.C_Valid === 1'b1 && n < 40) begin
            n++;
            @(negedge Clk);
        end
        chk("dlv_tmo_cycles", 32'(n), 32'd16);
        chk("dlv_tmo_pulse", 32'(Error_Valid), 32'd1);
        chk("dlv_tmo_code", 32'(Config_Error), 32'd5);
        @(negedge Clk);
        chk("dlv_tmo_status", 32'(Config_Status), 32'h2125);
        chk("dlv_tmo_no_notify", 32'(Config_Notification_Valid), 32'd0);

        // Reset while assembling a word.
        send_byte(8'h88);
        @(negedge Clk);
        Rst = 1'b1;
        #1;
        chk_reset_outputs("rst_asm");
        @(negedge Clk);
        Rst       = 1'b0;
        bus.Empty = 1'b1;
        @(negedge Clk);

        // Reset while holding a write on the bus.
        send_byte(8'h88);
        send_byte(8'h02);
        @(negedge Clk);
        @(negedge Clk);
        chk("rst_dlv_pre_valid", 32'(bus.C_Valid), 32'd1);
        Rst = 1'b1;
        #1;
        chk_reset_outputs("rst_dlv");
        @(negedge Clk);
        Rst       = 1'b0;
        bus.Empty = 1'b1;
        @(negedge Clk);
        chk("rst_dlv_no_notify", 32'(Config_Notification_Valid), 32'd0);
        chk("rst_dlv_no_err", 32'(Error_Valid), 32'd0);
        chk("rst_dlv_status", 32'(Config_Status), 32'h0002);
        apply_vec('{8'h80, 8'h05, 0, 0, 4'h0, 14'h0005, 3'd0, 16'h0005});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
